// File: rtl/dmem_check_pkg.sv
// Shared state encoding, log entry width and default constants for the
// data-memory store checker.
package dmem_check_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2
  } checkState_t;

  localparam int          LOG_ENTRY_W         = 64;
  localparam logic [31:0] DEFAULT_MAILBOX_ADR = 32'd100;
  localparam logic [31:0] DEFAULT_EXPECT_DATA = 32'd7;
  localparam logic [31:0] DEFAULT_ALLOW_ADR   = 32'd96;

  // Verdict for one store seen while the check is still running.
  function automatic checkState_t classifyStore(
    input logic [31:0] adr,
    input logic [31:0] data,
    input logic [31:0] mailboxAdr,
    input logic [31:0] expectData,
    input logic [31:0] allowAdr
  );
    checkState_t verdict;
    if (adr[1:0] != 2'b00) begin
      verdict = FAIL;
    end else if (adr == mailboxAdr) begin
      verdict = (data == expectData) ? PASS : FAIL;
    end else if (adr == allowAdr) begin
      verdict = RUN;
    end else begin
      verdict = FAIL;
    end
    return verdict;
  endfunction

endpackage

// File: rtl/write_log_fifo.sv
// Synchronous FIFO with show-ahead head output and a sticky overflow flag.
// Extra pointer MSB distinguishes full from empty.
module write_log_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] headData,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wrPtrReg;
  logic [PW:0]      rdPtrReg;
  logic             overflowReg;
  logic             doPush;
  logic             doPop;

  assign empty = (wrPtrReg == rdPtrReg);
  assign full  = (wrPtrReg[PW] != rdPtrReg[PW]) &&
                 (wrPtrReg[PW-1:0] == rdPtrReg[PW-1:0]);

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign doPush = push && (!full || pop);
  assign doPop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtrReg    <= '0;
      rdPtrReg    <= '0;
      overflowReg <= 1'b0;
    end else begin
      if (doPush) wrPtrReg <= wrPtrReg + 1'b1;
      if (doPop)  rdPtrReg <= rdPtrReg + 1'b1;
      if (push && full && !pop) overflowReg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush && !reset) mem[wrPtrReg[PW-1:0]] <= pushData;
  end

  assign headData = empty ? '0 : mem[rdPtrReg[PW-1:0]];
  assign overflow = overflowReg;

endmodule

// File: rtl/dmem_write_checker.sv
// Data RAM for the single-cycle core plus a store-classifying self-check FSM
// and a write log drained by the host.
module dmem_write_checker
  import dmem_check_pkg::*;
#(
  parameter int          RAM_WORDS   = 64,
  parameter logic [31:0] MAILBOX_ADR = DEFAULT_MAILBOX_ADR,
  parameter logic [31:0] EXPECT_DATA = DEFAULT_EXPECT_DATA,
  parameter logic [31:0] ALLOW_ADR   = DEFAULT_ALLOW_ADR,
  parameter int          LOG_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Done,
  output logic        Pass,
  output logic        LogValid,
  output logic [31:0] LogAdr,
  output logic [31:0] LogData,
  input  logic        LogPop,
  output logic        LogOverflow
);

  localparam int IDX_W = $clog2(RAM_WORDS);

  logic [31:0]            ram [RAM_WORDS];
  logic [IDX_W-1:0]       wordIdx;
  checkState_t            stateReg;
  checkState_t            stateNext;
  logic                   logPush;
  logic [LOG_ENTRY_W-1:0] logHead;
  logic                   logFull;
  logic                   logEmpty;

  // Upper address bits are dropped, so the RAM aliases every RAM_WORDS*4 bytes.
  assign wordIdx = DataAdr[IDX_W+1:2];

  always_ff @(posedge clk) begin
    if (MemWrite) ram[wordIdx] <= WriteData;
  end

  assign ReadData = ram[wordIdx];

  always_ff @(posedge clk) begin
    if (reset) stateReg <= RUN;
    else       stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    if (stateReg == RUN && MemWrite) begin
      stateNext = classifyStore(DataAdr, WriteData, MAILBOX_ADR,
                                EXPECT_DATA, ALLOW_ADR);
    end
  end

  always_comb begin
    Done = (stateReg != RUN);
    Pass = (stateReg == PASS);
  end

  // The store that ends the check is still logged; nothing after it is.
  assign logPush = MemWrite && (stateReg == RUN);

  write_log_fifo #(
    .WIDTH (LOG_ENTRY_W),
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .clk      (clk),
    .reset    (reset),
    .push     (logPush),
    .pushData ({DataAdr, WriteData}),
    .pop      (LogPop),
    .headData (logHead),
    .full     (logFull),
    .empty    (logEmpty),
    .overflow (LogOverflow)
  );

  assign LogValid = !logEmpty;
  assign LogAdr   = logHead[63:32];
  assign LogData  = logHead[31:0];

  always_ff @(posedge clk) begin
    if (!reset) assert (!(logFull && logEmpty));
  end

endmodule

// File: tb/tb_dmem_write_checker.sv
// Scenario bench for dmem_write_checker: expected log entries are queued
// when stores are driven and compared as the host drains the log.
module tb_dmem_write_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        Done, Pass, LogValid, LogOverflow;
  logic [31:0] LogAdr, LogData;
  logic        LogPop = 1'b0;

  int tests = 0;
  int fails = 0;
  logic [63:0] sb [$];

  always #5 clk = ~clk;

  dmem_write_checker dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .ReadData(ReadData), .Done(Done), .Pass(Pass),
    .LogValid(LogValid), .LogAdr(LogAdr), .LogData(LogData),
    .LogPop(LogPop), .LogOverflow(LogOverflow)
  );

  // Called at a negedge; returns at the next negedge after the store's edge.
  task automatic store(input logic [31:0] a, input logic [31:0] d,
                       input bit logged, input bit pop);
    MemWrite = 1'b1; DataAdr = a; WriteData = d; LogPop = pop;
    @(negedge clk);
    MemWrite = 1'b0; LogPop = 1'b0;
    if (logged) sb.push_back({a, d});
    $display("[TB] store adr=%0d data=0x%0h pop=%0d -> Done=%0b Pass=%0b LogValid=%0b",
             a, d, pop, Done, Pass, LogValid);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic check_flags(input string name, input logic expDone, input logic expPass);
    tests++;
    if ({Done, Pass} !== {expDone, expPass}) begin
      fails++;
      $display("FAIL %s: Done/Pass got %b%b, want %b%b", name, Done, Pass, expDone, expPass);
    end
  endtask

  task automatic check_read(input string name, input logic [31:0] a, input logic [31:0] exp);
    DataAdr = a; MemWrite = 1'b0;
    #1;
    tests++;
    if (ReadData !== exp) begin
      fails++;
      $display("FAIL %s: ReadData@%0d got 0x%0h, want 0x%0h", name, a, ReadData, exp);
    end
    $display("[TB] load adr=%0d data=0x%0h", a, ReadData);
  endtask

  task automatic drain(input string name);
    logic [63:0] exp;
    for (int n = 0; n < 16 && sb.size() > 0; n++) begin
      exp = sb.pop_front();
      tests++;
      if (LogValid !== 1'b1 || {LogAdr, LogData} !== exp) begin
        fails++;
        $display("FAIL %s: log head valid=%b adr=%0d data=0x%0h, want adr=%0d data=0x%0h",
                 name, LogValid, LogAdr, LogData, exp[63:32], exp[31:0]);
      end
      $display("[TB] pop adr=%0d data=0x%0h", LogAdr, LogData);
      LogPop = 1'b1;
      @(negedge clk);
      LogPop = 1'b0;
    end
    tests++;
    if (LogValid !== 1'b0 || LogAdr !== 32'd0 || LogData !== 32'd0) begin
      fails++;
      $display("FAIL %s: log not empty after drain valid=%b adr=%0d data=0x%0h",
               name, LogValid, LogAdr, LogData);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    tests++;
    if ({Done, Pass, LogValid, LogAdr, LogData, LogOverflow} !== 68'd0) begin
      fails++;
      $display("FAIL reset: Done=%b Pass=%b LogValid=%b LogAdr=%0d LogData=%0d LogOverflow=%b, want all 0",
               Done, Pass, LogValid, LogAdr, LogData, LogOverflow);
    end
  endtask

  task automatic test_pass();
    apply_reset();
    store(32'd96, 32'h5, 1'b1, 1'b0);
    check_flags("pass_allow", 1'b0, 1'b0);
    store(32'd100, 32'd7, 1'b1, 1'b0);
    check_flags("pass_mailbox", 1'b1, 1'b1);
    check_read("pass_load96", 32'd96, 32'h5);
    drain("pass_log");
  endtask

  task automatic test_fail_data();
    apply_reset();
    store(32'd100, 32'd3, 1'b1, 1'b0);
    check_flags("fail_data", 1'b1, 1'b0);
    store(32'd100, 32'd7, 1'b0, 1'b0);
    check_flags("fail_terminal", 1'b1, 1'b0);
    check_read("fail_ram_still_written", 32'd100, 32'd7);
    drain("fail_data_log");
  endtask

  task automatic test_fail_addr();
    logic [31:0] adrs [3];
    adrs[0] = 32'd92; adrs[1] = 32'd98; adrs[2] = 32'd352;
    for (int i = 0; i < 3; i++) begin
      apply_reset();
      store(adrs[i], 32'hA5A5_0000 + i, 1'b1, 1'b0);
      check_flags($sformatf("fail_adr_%0d", adrs[i]), 1'b1, 1'b0);
      drain($sformatf("fail_adr_log_%0d", adrs[i]));
    end
    check_read("alias_word24", 32'd96, 32'hA5A5_0002);
  endtask

  task automatic test_overflow(input bit popOn9th);
    string name;
    name = popOn9th ? "full_push_pop" : "overflow";
    apply_reset();
    for (int i = 0; i < 8; i++) store(32'd96, 32'd100 + i, 1'b1, 1'b0);
    if (popOn9th) void'(sb.pop_front());
    store(32'd96, 32'd200, popOn9th, popOn9th);
    tests++;
    if (LogOverflow !== !popOn9th) begin
      fails++;
      $display("FAIL %s: LogOverflow got %b, want %b", name, LogOverflow, !popOn9th);
    end
    check_flags({name, "_run"}, 1'b0, 1'b0);
    drain({name, "_log"});
  endtask

  task automatic test_empty_pop();
    apply_reset();
    LogPop = 1'b1;
    @(negedge clk);
    LogPop = 1'b0;
    tests++;
    if (LogValid !== 1'b0 || LogOverflow !== 1'b0) begin
      fails++;
      $display("FAIL empty_pop: LogValid=%b LogOverflow=%b, want 0 0", LogValid, LogOverflow);
    end
    store(32'd96, 32'h11, 1'b1, 1'b1);
    drain("empty_push_pop");
  endtask

  task automatic test_reset_midcheck();
    apply_reset();
    store(32'd92, 32'hDEAD_BEEF, 1'b1, 1'b0);
    check_flags("mid_fail", 1'b1, 1'b0);
    apply_reset();
    tests++;
    if (Done !== 1'b0 || LogValid !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: Done=%b LogValid=%b, want 0 0", Done, LogValid);
    end
    check_read("mid_ram_survives", 32'd92, 32'hDEAD_BEEF);
    // Reset wins over a simultaneous mailbox store, but the RAM write lands.
    reset = 1'b1; MemWrite = 1'b1; DataAdr = 32'd100; WriteData = 32'd7;
    @(negedge clk);
    reset = 1'b0; MemWrite = 1'b0;
    check_flags("reset_vs_store", 1'b0, 1'b0);
    tests++;
    if (LogValid !== 1'b0) begin
      fails++;
      $display("FAIL reset_vs_push: LogValid got %b, want 0", LogValid);
    end
    check_read("reset_vs_store_ram", 32'd100, 32'd7);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_pass();
    test_fail_data();
    test_fail_addr();
    test_overflow(1'b0);
    test_overflow(1'b1);
    test_empty_pop();
    test_reset_midcheck();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
